// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor command sequencer.
//
// Contents:
//   state_t          sequencer states
//   NUM_CFG, NUM_RD  number of config writes and reads per data-ready burst
//   CFG_* / RD_*     sensor config write commands and read register addresses
//   cfg_cmd, rd_cmd  map a step index onto the command sent to the SPI monarch
//
// Build option: INERT_YAW_EN adds the yaw-rate byte pair to each read burst.

package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG,
        IDLE,
        RD,
        VLD
    } state_t;

    localparam int unsigned NUM_CFG = 4;

`ifdef INERT_YAW_EN
    localparam int unsigned NUM_RD = 6;
`else
    localparam int unsigned NUM_RD = 4;
`endif

    // Step counter is shared by the config and read tables.
    localparam int unsigned STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;

    // Config writes: {addr, data}
    localparam logic [15:0] CFG_INT_DRDY = 16'h0D02;  // INT on data-ready
    localparam logic [15:0] CFG_ACCEL    = 16'h1160;  // accel 416Hz +/-2g
    localparam logic [15:0] CFG_GYRO     = 16'h1250;  // gyro 208Hz 245dps
    localparam logic [15:0] CFG_ROUND    = 16'h1460;  // rounding

    // Read addresses (R/W bit already set)
    localparam logic [7:0] RD_PTCH_L = 8'hA2;
    localparam logic [7:0] RD_PTCH_H = 8'hA3;
    localparam logic [7:0] RD_AZ_L   = 8'hAC;
    localparam logic [7:0] RD_AZ_H   = 8'hAD;
    localparam logic [7:0] RD_YAW_L  = 8'hA6;
    localparam logic [7:0] RD_YAW_H  = 8'hA7;

    function automatic logic [15:0] cfg_cmd(input step_t idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = CFG_INT_DRDY;
            3'd1:    c = CFG_ACCEL;
            3'd2:    c = CFG_GYRO;
            3'd3:    c = CFG_ROUND;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] rd_cmd(input step_t idx);
        logic [7:0] a;
        case (idx)
            3'd0:    a = RD_PTCH_L;
            3'd1:    a = RD_PTCH_H;
            3'd2:    a = RD_AZ_L;
            3'd3:    a = RD_AZ_H;
            3'd4:    a = RD_YAW_L;
            3'd5:    a = RD_YAW_H;
            default: a = 8'h00;
        endcase
        return {a, 8'h00};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (both flops clear to 0)
//   d      in   asynchronous input
//   q      out  synchronized output (second flop)

module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= '0;
            q   <= '0;
        end else begin
            ff1 <= d;
            q   <= ff1;
        end
    end

endmodule

// File: rtl/inert_intf.sv
// Command sequencer for the inertial sensor, upstream of the SPI monarch.
// After a power-up delay it writes the sensor config registers, then on every
// data-ready INT reads pitch rate and Z accel byte pairs and presents them as
// signed 16-bit values with a one-clock vld pulse.
//
// Parameters:
//   TMR_W    power-up timer width; config starts once the timer is all-ones
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   INT      in   sensor data-ready, asynchronous level
//   done     in   SPI transaction complete (level, held until next wrt)
//   rd_data  in   SPI read data, register byte in [7:0]
//   wrt      out  one-clock pulse starting an SPI transaction
//   cmd      out  {R/W+addr, data}, held between transactions
//   ptch_rt  out  signed pitch rate
//   AZ       out  signed Z acceleration
//   yaw_rt   out  signed yaw rate (INERT_YAW_EN builds only, else 0)
//   vld      out  one-clock pulse when the outputs update
//
// Build option: INERT_YAW_EN appends the yaw byte pair to each read burst.

module inert_intf
    import inert_pkg::*;
#(
    parameter int unsigned TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    // Timer value one below all-ones: moving to CFG here means the timer
    // lands on all-ones as config starts.
    localparam logic [TMR_W-1:0] TMR_PENULT = ~TMR_W'(1);
    localparam step_t LAST_CFG = step_t'(NUM_CFG - 1);
    localparam step_t LAST_RD  = step_t'(NUM_RD - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    step_t            step;
    logic             busy;       // transaction issued, awaiting done_rise
    logic             done_q;
    logic             done_rise;
    logic             int_sync;
    logic [7:0]       hold [NUM_RD];

    // Only the register byte is used; the upper byte is SPI filler.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    sync_2ff #(
        .WIDTH (1)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .q     (int_sync)
    );

    assign done_rise = done & ~done_q;

`ifndef INERT_YAW_EN
    assign yaw_rt = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWR_WAIT;
            timer   <= '0;
            step    <= '0;
            busy    <= 1'b0;
            done_q  <= 1'b0;
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
            vld     <= 1'b0;
`ifdef INERT_YAW_EN
            yaw_rt  <= 16'h0000;
`endif
            for (int i = 0; i < NUM_RD; i++) begin
                hold[i] <= 8'h00;
            end
        end else begin
            done_q <= done;
            // wrt and vld are single-cycle pulses unless re-asserted below.
            wrt    <= 1'b0;
            vld    <= 1'b0;

            case (state)
                PWR_WAIT: begin
                    timer <= timer + 1'b1;
                    if (timer == TMR_PENULT) begin
                        state <= CFG;
                        step  <= '0;
                        busy  <= 1'b0;
                    end
                end

                CFG: begin
                    if (!busy) begin
                        wrt  <= 1'b1;
                        cmd  <= cfg_cmd(step);
                        busy <= 1'b1;
                    end else if (done_rise) begin
                        busy <= 1'b0;
                        if (step == LAST_CFG) begin
                            step  <= '0;
                            state <= IDLE;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end

                IDLE: begin
                    step <= '0;
                    busy <= 1'b0;
                    if (int_sync) begin
                        state <= RD;
                    end
                end

                RD: begin
                    if (!busy) begin
                        wrt  <= 1'b1;
                        cmd  <= rd_cmd(step);
                        busy <= 1'b1;
                    end else if (done_rise) begin
                        busy <= 1'b0;
                        for (int i = 0; i < NUM_RD; i++) begin
                            if (step == step_t'(i)) begin
                                hold[i] <= rd_data[7:0];
                            end
                        end
                        if (step == LAST_RD) begin
                            // Final byte comes straight from rd_data so every
                            // output updates on the same edge as vld.
                            step    <= '0;
                            state   <= VLD;
                            vld     <= 1'b1;
                            ptch_rt <= {hold[1], hold[0]};
`ifdef INERT_YAW_EN
                            AZ      <= {hold[3], hold[2]};
                            yaw_rt  <= {rd_data[7:0], hold[4]};
`else
                            AZ      <= {rd_data[7:0], hold[2]};
`endif
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end

                VLD: begin
                    state <= IDLE;
                end

                default: begin
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf with TMR_W=4 and a done-responder stub that
// answers each wrt three cycles later with a byte chosen by register address.

module tb_inert_intf;

`ifdef INERT_YAW_EN
    localparam int NRD = 6;
`else
    localparam int NRD = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic [15:0] yaw_rt;
    logic        vld;

    inert_intf #(
        .TMR_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .yaw_rt  (yaw_rt),
        .vld     (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Stub / monitor state
    logic [15:0] log_q [$];
    logic [7:0]  p_l, p_h, a_l, a_h, y_l, y_h;
    logic [7:0]  cur_addr;
    int          dly = 0;
    int          neg_cnt = 0;
    int          done_neg = -10;
    int          vld_cnt = 0;
    int          proto_err = 0;
    int          lat_err = 0;
    int          stable_err = 0;
    logic        outstanding = 1'b0;
    logic [15:0] prev_p = 16'h0, prev_a = 16'h0, prev_y = 16'h0;

    function automatic logic [7:0] resp(input logic [7:0] addr);
        case (addr)
            8'hA2:   return p_l;
            8'hA3:   return p_h;
            8'hAC:   return a_l;
            8'hAD:   return a_h;
            8'hA6:   return y_l;
            8'hA7:   return y_h;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        neg_cnt++;
        if (!rst_n) begin
            done        = 1'b0;
            dly         = 0;
            outstanding = 1'b0;
        end else begin
            if (wrt) begin
                if (outstanding) proto_err++;
                outstanding = 1'b1;
                log_q.push_back(cmd);
                cur_addr = cmd[15:8];
                done     = 1'b0;
                dly      = 3;
            end else if (dly != 0) begin
                dly--;
                if (dly == 0) begin
                    done        = 1'b1;
                    rd_data     = {8'hEE, resp(cur_addr)};
                    outstanding = 1'b0;
                    done_neg    = neg_cnt;
                end
            end
            if (vld) begin
                vld_cnt++;
                if (neg_cnt != done_neg + 1) lat_err++;
            end else if (ptch_rt !== prev_p || AZ !== prev_a || yaw_rt !== prev_y) begin
                stable_err++;
            end
        end
        prev_p = ptch_rt;
        prev_a = AZ;
        prev_y = yaw_rt;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int target, input int budget);
        int n = 0;
        while (log_q.size() < target && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_vld(input int target, input int budget, input string tag);
        int n = 0;
        while (vld_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, (vld_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Cycles from reset release (just after a negedge) to the first wrt seen.
    task automatic measure_pwrup(input string tag);
        int n = 0;
        while (!wrt && n < 100) begin
            tick(1);
            n++;
        end
        check(tag, n, 32'd16);
    endtask

    task automatic check_cfg(input int base, input string tag);
        logic [15:0] exp_cfg [4];
        exp_cfg = '{16'h0D02, 16'h1160, 16'h1250, 16'h1460};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_cfg%0d", tag, i),
                  (log_q.size() > base + i) ? log_q[base + i] : 16'hxxxx, exp_cfg[i]);
        end
    endtask

    logic [15:0] exp_rd [6];
    logic [15:0] exp_yaw;
    int          v0;
    int          l0;

    initial begin
        exp_rd = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00, 16'hA600, 16'hA700};
        rst_n   = 1'b0;
        INT     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        {p_l, p_h, a_l, a_h, y_l, y_h} = {8'h34, 8'h12, 8'hCD, 8'hAB, 8'h78, 8'h56};

        // Reset state
        tick(3);
        check("rst_wrt", wrt, 1'b0);
        check("rst_cmd", cmd, 16'h0);
        check("rst_ptch", ptch_rt, 16'h0);
        check("rst_az", AZ, 16'h0);
        check("rst_yaw", yaw_rt, 16'h0);
        check("rst_vld", vld, 1'b0);

        // Power-up delay then config table
        rst_n = 1'b1;
        measure_pwrup("pwrup_delay");
        wait_log(4, 100);
        tick(12);
        check("cfg_count", log_q.size(), 32'd4);
        check_cfg(0, "pwr1");

        // Single burst
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_vld(1, 150, "burst1_vld");
        tick(5);
`ifdef INERT_YAW_EN
        exp_yaw = 16'h5678;
`else
        exp_yaw = 16'h0000;
`endif
        check("b1_ptch", ptch_rt, 16'h1234);
        check("b1_az", AZ, 16'hABCD);
        check("b1_yaw", yaw_rt, exp_yaw);
        check("b1_vldcnt", vld_cnt, 32'd1);
        check("b1_wrtcnt", log_q.size(), 4 + NRD);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("b1_rd%0d", i), log_q[4 + i], exp_rd[i]);
        end
        check("b1_cmd_hold", cmd, exp_rd[NRD - 1]);
        check("b1_latency", lat_err, 32'd0);

        // INT held high: back-to-back bursts, negative AZ
        {p_l, p_h, a_l, a_h, y_l, y_h} = {8'h5A, 8'h4B, 8'h01, 8'h80, 8'h11, 8'h22};
        INT = 1'b1;
        wait_vld(4, 400, "held_vld");
        INT = 1'b0;
        tick(80);
`ifdef INERT_YAW_EN
        exp_yaw = 16'h2211;
`else
        exp_yaw = 16'h0000;
`endif
        check("held_ptch", ptch_rt, 16'h4B5A);
        check("held_az", AZ, 16'h8001);
        check("held_yaw", yaw_rt, exp_yaw);
        check("held_wrtcnt", log_q.size(), 4 + NRD * vld_cnt);
        check("held_stable", stable_err, 32'd0);

        // INT toggling mid-burst is ignored
        v0 = vld_cnt;
        l0 = log_q.size();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_log(l0 + 2, 100);
        repeat (2) begin
            INT = 1'b1;
            tick(2);
            INT = 1'b0;
            tick(2);
        end
        tick(80);
        check("tog_vldcnt", vld_cnt, v0 + 1);
        check("tog_wrtcnt", log_q.size(), l0 + NRD);

        // Reset during the second read of a burst
        {p_l, p_h, a_l, a_h, y_l, y_h} = {8'h34, 8'h12, 8'hCD, 8'hAB, 8'h78, 8'h56};
        v0 = vld_cnt;
        l0 = log_q.size();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_log(l0 + 2, 100);
        tick(1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ptch", ptch_rt, 16'h0);
        check("mid_rst_az", AZ, 16'h0);
        check("mid_rst_yaw", yaw_rt, 16'h0);
        check("mid_rst_cmd", cmd, 16'h0);
        check("mid_rst_wrt", wrt, 1'b0);
        tick(3);
        rst_n = 1'b1;
        measure_pwrup("pwrup_delay2");
        wait_log(l0 + 6, 100);
        tick(12);
        check("rst_partial_wrts", log_q.size(), l0 + 6);
        check_cfg(l0 + 2, "pwr2");
        check("rst_no_vld", vld_cnt, v0);

        // Recovery burst after reset
`ifdef INERT_YAW_EN
        exp_yaw = 16'h5678;
`else
        exp_yaw = 16'h0000;
`endif
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_vld(v0 + 1, 150, "rec_vld");
        tick(5);
        check("rec_ptch", ptch_rt, 16'h1234);
        check("rec_az", AZ, 16'hABCD);
        check("rec_yaw", yaw_rt, exp_yaw);

        check("protocol", proto_err, 32'd0);
        check("latency", lat_err, 32'd0);
        check("stable", stable_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
